// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8:1 mux round-robin arbiter.
//   state_t      : FSM encoding (IDLE=0, GRANT=1)
//   N_REQ/SEL_W  : requester count and mux select width
//   HOLD_MAX_DEF : default hold limit for the optional timeout feature
package mux_arb_pkg;

  localparam int unsigned N_REQ        = 8;
  localparam int unsigned SEL_W        = 3;
  localparam int unsigned HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 7->0.
//   req [7:0] : request vector
//   ptr [2:0] : search start position
//   any       : at least one request set
//   idx [2:0] : chosen requester (valid when any=1)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   enc;

  // Rotate right by ptr so the search start lands on bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    enc = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) enc = SEL_W'(i);
    end
  end

  // Undo the rotation; 3-bit addition wraps mod 8.
  assign idx = enc + ptr;
  assign any = |req;

endmodule : rr_pick

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of the 8:1 data mux.
//   clk, rst (sync, active-high)
//   req  [7:0] : level requests, held until served
//   done       : owner release pulse
//   sel  [2:0] : registered mux select (holds value while idle)
//   gnt  [7:0] : registered one-hot grant, zero when idle
//   valid      : grant active
//   timeout    : one-cycle pulse on forced release
// Optional feature macro: ARB_TIMEOUT_EN (hold limit HOLD_MAX cycles per grant).
module mux8_rr_arbiter
  import mux_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             pick_any_c;
  logic [SEL_W-1:0] pick_idx_c;
  logic             release_c;
  logic             force_c;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any_c),
    .idx (pick_idx_c)
  );

  // Either a done pulse or the owner dropping its request ends the grant.
  assign release_c = done | ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign force_c = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign timeout = timeout_q;
`else
  assign force_c = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and output register inputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d = GRANT;
          sel_d   = pick_idx_c;
          gnt_d   = N_REQ'(1) << pick_idx_c;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_c || force_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          // A normal release on the limit cycle is not reported as a timeout.
          timeout_d = ~release_c;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;

endmodule : mux8_rr_arbiter

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: cycle model feeds a scoreboard queue,
// plus directed checks of grant order, bubbles, releases, timeout and reset.
module tb_mux8_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       timeout;

  int n_asrt;
  int n_fail;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  bit       m_busy;
  bit [2:0] m_sel;
  bit [2:0] m_ptr;
  int       m_cnt;
  bit       m_to;

`ifdef ARB_TIMEOUT_EN
  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
`else
  mux8_rr_arbiter dut (
`endif
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge with the currently driven inputs.
  task automatic model_step();
    bit rel;
    bit frc;
    bit found;
    exp_t e;
    m_to = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_sel = 3'd0; m_ptr = 3'd0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (int'(m_ptr) + k) % 8;
        if (!found && req[j]) begin
          found = 1'b1;
          m_sel = 3'(j);
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      rel = done || !req[m_sel];
`ifdef ARB_TIMEOUT_EN
      frc = (m_cnt == int'(HOLD) - 1);
`else
      frc = 1'b0;
`endif
      if (rel || frc) begin
        m_busy = 1'b0;
        m_ptr  = 3'((int'(m_sel) + 1) % 8);
        m_to   = !rel;
      end else begin
        m_cnt++;
      end
    end
    e.sel   = m_sel;
    e.gnt   = m_busy ? (8'd1 << m_sel) : 8'd0;
    e.valid = m_busy;
    e.to    = m_to;
    sb.push_back(e);
  endtask

  // One clock: predict, clock, then compare outputs and invariants.
  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sel", 32'(sel), 32'(e.sel));
    check("gnt", 32'(gnt), 32'(e.gnt));
    check("valid", 32'(valid), 32'(e.valid));
    check("timeout", 32'(timeout), 32'(e.to));
    check("inv_onehot", 32'((gnt & (gnt - 8'd1)) == 8'd0), 32'd1);
    check("inv_valid_or", 32'(valid), 32'(|gnt));
    check("inv_gnt_sel", 32'(gnt[sel]), 32'(valid));
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    n_asrt = 0;
    n_fail = 0;
    m_busy = 1'b0; m_sel = 3'd0; m_ptr = 3'd0; m_cnt = 0; m_to = 1'b0;
    rst = 1'b1; req = 8'hFF; done = 1'b0;

    // Reset held two cycles with all requests asserted.
    step();
    step();
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_gnt", 32'(gnt), 32'd0);

    // Single request.
    req = 8'b0001_0000; rst = 1'b0;
    do_reset();
    step();
    check("single_sel", 32'(sel), 32'd4);
    check("single_gnt", 32'(gnt), 32'h10);
    step(); step();
    done = 1'b1; step(); done = 1'b0;
    check("single_rel", 32'(valid), 32'd0);
    req = 8'h21; step();
    check("single_ptr5", 32'(sel), 32'd5);
    req = 8'h00; step();

    // Rotation with all requests held; one bubble between grants and 7->0 wrap.
    req = 8'hFF;
    do_reset();
    for (int g = 0; g < 9; g++) begin
      n = 0;
      while (!valid && n < 5) begin
        step();
        n++;
      end
      check("rot_valid", 32'(valid), 32'd1);
      check("rot_order", 32'(sel), 32'(g % 8));
      check("rot_bubble", 32'(n), 32'd1);
      done = 1'b1; step(); done = 1'b0;
    end

    // Owner drops request together with done: single release, search from 3.
    req = 8'h00;
    do_reset();
    req = 8'h04; step();
    check("drop_sel2", 32'(sel), 32'd2);
    req = 8'h00; done = 1'b1; step(); done = 1'b0;
    check("drop_rel", 32'(valid), 32'd0);
    req = 8'b0000_0101; step();
    check("drop_wrap0", 32'(sel), 32'd0);
    req = 8'h00; step(); step();

    // Long hold on requester 6.
    do_reset();
    req = 8'h40; step();
    check("hold_sel6", 32'(sel), 32'd6);
`ifdef ARB_TIMEOUT_EN
    step(); step(); step();
    check("to_still_valid", 32'(valid), 32'd1);
    step();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_released", 32'(valid), 32'd0);
    req = 8'hC0; step();
    check("to_next7", 32'(sel), 32'd7);
    check("to_pulse_end", 32'(timeout), 32'd0);
`else
    for (int c = 0; c < 100; c++) step();
    check("hold_valid", 32'(valid), 32'd1);
    check("hold_sel", 32'(sel), 32'd6);
    check("hold_no_to", 32'(timeout), 32'd0);
`endif
    req = 8'h00; step(); step();

    // Reset in the middle of a grant.
    do_reset();
    req = 8'h20; step();
    check("mid_sel5", 32'(sel), 32'd5);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    req = 8'h21; step();
    check("mid_grant0", 32'(sel), 32'd0);
    check("mid_gnt0", 32'(gnt), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule : tb_mux8_rr_arbiter
